// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and bit-level helpers for the
// configurable UART core.
package uart_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] TICK_LAST  = 4'd15;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_e;

    // Payload is zero-extended to 9 bits, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
        logic p_s;
        p_s = ^data;
        case (mode)
            PAR_ODD:  return ~p_s;
            PAR_EVEN: return p_s;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud16.sv
// Free-running 16x baud tick generator; a new divisor is picked up only when
// the counter wraps so a running period is never truncated.
module uart_baud16 #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick16
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_r;

    // Count 0..div_r, pulse tick on the wrap and reload the divisor there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            div_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == div_r) begin
            cnt_r  <= '0;
            div_r  <= baud_div;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick16 = tick_r;

endmodule

// File: rtl/uart_cfg_core_chk.sv
// Elaboration-time legality checks on the frame format parameters.
module uart_cfg_core_chk #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) ();

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_cfg_core: DATA_BITS=%0d outside 5..9", DATA_BITS);
    end

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_cfg_core: PARITY=%0d outside 0..2", PARITY);
    end

    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_cfg_core: STOP_BITS=%0d outside 1..2", STOP_BITS);
    end

endmodule

// File: rtl/uart_cfg_core.sv
// UART transceiver with elaboration-fixed frame format, run-time baud divisor,
// 16x oversampled majority-vote receiver and internal loopback.
module uart_cfg_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 loopback,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam parity_e    PAR_MODE     = parity_e'(PARITY[1:0]);
    localparam logic [3:0] LAST_BIT     = 4'(DATA_BITS - 1);
    // Ready rises one tick early so a back-to-back start lands exactly at stop end
    localparam logic [4:0] TX_STOP_LAST = 5'(OVERSAMPLE * STOP_BITS - 2);

    logic tick16_s;

    uart_cfg_core_chk #(
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) u_chk ();

    uart_baud16 #(.DIV_W(DIV_W)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .tick16   (tick16_s)
    );

    tx_state_e            tx_state_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic [4:0]           tx_cnt_r;
    logic [3:0]           tx_idx_r;
    logic                 tx_line_r;
    logic                 tx_ready_r;
    logic                 tx_pin_r;

    // TX sequencer: start bit on the first tick after accept, 16 ticks per bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_cnt_r   <= 5'd0;
            tx_idx_r   <= 4'd0;
            tx_line_r  <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_pin_r   <= 1'b1;
        end else begin
            tx_pin_r <= tx_line_r | loopback;
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_valid && tx_ready_r) begin
                        tx_shift_r <= tx_data;
                        tx_par_r   <= parity_bit(9'(tx_data), PAR_MODE);
                        tx_cnt_r   <= 5'd0;
                        tx_ready_r <= 1'b0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick16_s) begin
                        if (tx_line_r) begin
                            tx_line_r <= 1'b0;
                            tx_cnt_r  <= 5'd0;
                        end else if (tx_cnt_r[3:0] == TICK_LAST) begin
                            tx_line_r  <= tx_shift_r[0];
                            tx_cnt_r   <= 5'd0;
                            tx_idx_r   <= 4'd0;
                            tx_state_r <= TX_DATA;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 5'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick16_s) begin
                        if (tx_cnt_r[3:0] == TICK_LAST) begin
                            tx_cnt_r <= 5'd0;
                            if (tx_idx_r == LAST_BIT) begin
                                if (PAR_MODE != PAR_NONE) begin
                                    tx_line_r  <= tx_par_r;
                                    tx_state_r <= TX_PARITY;
                                end else begin
                                    tx_line_r  <= 1'b1;
                                    tx_state_r <= TX_STOP;
                                end
                            end else begin
                                tx_idx_r   <= tx_idx_r + 4'd1;
                                tx_line_r  <= tx_shift_r[1];
                                tx_shift_r <= tx_shift_r >> 1;
                            end
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 5'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick16_s) begin
                        if (tx_cnt_r[3:0] == TICK_LAST) begin
                            tx_cnt_r   <= 5'd0;
                            tx_line_r  <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 5'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick16_s) begin
                        if (tx_cnt_r == TX_STOP_LAST) begin
                            tx_cnt_r   <= 5'd0;
                            tx_ready_r <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_line_r  <= 1'b1;
                    tx_ready_r <= 1'b1;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_pin_r;
    assign tx_ready = tx_ready_r;

    logic                 rx_src_s;
    logic                 vote_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    rx_state_e            rx_state_r;
    logic [3:0]           rx_cnt_r;
    logic [3:0]           rx_idx_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_s7_r;
    logic                 rx_s8_r;
    logic                 rx_perr_r;
    logic                 rx_valid_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_parity_err_r;
    logic                 rx_frame_err_r;

    assign rx_src_s = loopback ? tx_line_r : rx;
    assign vote_s   = majority3(rx_s7_r, rx_s8_r, rx_sync_r);

    // RX: synchronise, detect start edge, vote ticks 7/8/9, pulse valid in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r       <= 1'b1;
            rx_sync_r       <= 1'b1;
            rx_prev_r       <= 1'b1;
            rx_state_r      <= RX_IDLE;
            rx_cnt_r        <= 4'd0;
            rx_idx_r        <= 4'd0;
            rx_shift_r      <= '0;
            rx_s7_r         <= 1'b1;
            rx_s8_r         <= 1'b1;
            rx_perr_r       <= 1'b0;
            rx_valid_r      <= 1'b0;
            rx_data_r       <= '0;
            rx_parity_err_r <= 1'b0;
            rx_frame_err_r  <= 1'b0;
        end else begin
            rx_meta_r  <= rx_src_s;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    // Needs a 1->0 edge, so a stuck-low stop bit cannot retrigger
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_cnt_r   <= 4'd0;
                        rx_idx_r   <= 4'd0;
                        rx_perr_r  <= 1'b0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
                    if (tick16_s) begin
                        rx_cnt_r <= rx_cnt_r + 4'd1;
                        if (rx_cnt_r == SAMPLE_LO) begin
                            rx_s7_r <= rx_sync_r;
                        end
                        if (rx_cnt_r == SAMPLE_MID) begin
                            rx_s8_r <= rx_sync_r;
                        end
                        case (rx_state_r)
                            RX_START: begin
                                if (rx_cnt_r == SAMPLE_HI && vote_s) begin
                                    rx_state_r <= RX_IDLE;
                                end else if (rx_cnt_r == TICK_LAST) begin
                                    rx_state_r <= RX_DATA;
                                end
                            end
                            RX_DATA: begin
                                if (rx_cnt_r == SAMPLE_HI) begin
                                    rx_shift_r <= {vote_s, rx_shift_r[DATA_BITS-1:1]};
                                end
                                if (rx_cnt_r == TICK_LAST) begin
                                    if (rx_idx_r == LAST_BIT) begin
                                        rx_state_r <= (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                                    end else begin
                                        rx_idx_r <= rx_idx_r + 4'd1;
                                    end
                                end
                            end
                            RX_PARITY: begin
                                if (rx_cnt_r == SAMPLE_HI) begin
                                    rx_perr_r <= vote_s ^ parity_bit(9'(rx_shift_r), PAR_MODE);
                                end
                                if (rx_cnt_r == TICK_LAST) begin
                                    rx_state_r <= RX_STOP;
                                end
                            end
                            RX_STOP: begin
                                if (rx_cnt_r == SAMPLE_HI) begin
                                    rx_valid_r      <= 1'b1;
                                    rx_data_r       <= rx_shift_r;
                                    rx_parity_err_r <= rx_perr_r;
                                    rx_frame_err_r  <= ~vote_s;
                                    rx_state_r      <= RX_DONE;
                                end
                            end
                            default: rx_state_r <= RX_IDLE;
                        endcase
                    end
                end
                RX_DONE: rx_state_r <= RX_IDLE;
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid      = rx_valid_r;
    assign rx_data       = rx_data_r;
    assign rx_parity_err = rx_parity_err_r;
    assign rx_frame_err  = rx_frame_err_r;

endmodule
